fp_align_pipe: RTL and testbench

Parametrised, two-stage pipelined operand-alignment unit for the floating-point adder datapath. It accepts two IEEE-754-style operands and orders them by magnitude, so the larger one is always "big". It restores hidden bits and right-shifts the smaller mantissa to the larger exponent, producing guard/round/sticky bits. The result goes to the adder/rounder stage under a valid/ready handshake. It sits between operand capture and the mantissa add/subtract stage in the Maxnet neuron accumulator.

---
 rtl/fp_align_if.sv | 40 ++++
 rtl/fp_align_pipe.sv | 165 ++++++++++++++++
 tb/tb_fp_align_pipe.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/fp_align_if.sv
// Operand-pair / aligned-result bundle between operand capture, the alignment
// pipe and the mantissa add/subtract stage.
interface fp_align_if #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23
);
  localparam int AW = MANT_W + 4;

  logic              in_valid;
  logic              in_ready;
  logic              a_sign;
  logic              b_sign;
  logic [EXP_W-1:0]  a_exp;
  logic [EXP_W-1:0]  b_exp;
  logic [MANT_W-1:0] a_mant;
  logic [MANT_W-1:0] b_mant;

  logic              out_valid;
  logic              out_ready;
  logic [EXP_W-1:0]  out_exp;
  logic [AW-1:0]     out_big_mant;
  logic [AW-1:0]     out_little_mant;
  logic              out_big_sign;
  logic              out_little_sign;
  logic              out_swap;
  logic              out_eff_sub;
  logic              out_special;

  modport master (
    output in_valid, a_sign, b_sign, a_exp, b_exp, a_mant, b_mant, out_ready,
    input  in_ready, out_valid, out_exp, out_big_mant, out_little_mant,
           out_big_sign, out_little_sign, out_swap, out_eff_sub, out_special
  );

  modport slave (
    input  in_valid, a_sign, b_sign, a_exp, b_exp, a_mant, b_mant, out_ready,
    output in_ready, out_valid, out_exp, out_big_mant, out_little_mant,
           out_big_sign, out_little_sign, out_swap, out_eff_sub, out_special
  );
endinterface

// File: rtl/fp_align_pipe.sv
// Two-stage FP operand alignment: order operands by magnitude, then shift the
// smaller mantissa to the larger exponent with guard/round/sticky collection.
module fp_align_pipe #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23
) (
  input  logic      clk,
  input  logic      rst,
  fp_align_if.slave bus
);
  localparam int AW = MANT_W + 4;
  localparam int KW = EXP_W + MANT_W;

  typedef struct packed {
    logic              big_sign;
    logic              little_sign;
    logic              swap;
    logic              special;
    logic [EXP_W-1:0]  big_exp;
    logic [EXP_W-1:0]  d;
    logic              big_hid;
    logic              little_hid;
    logic [MANT_W-1:0] big_mant;
    logic [MANT_W-1:0] little_mant;
  } s1_t;

  typedef struct packed {
    logic              big_sign;
    logic              little_sign;
    logic              swap;
    logic              eff_sub;
    logic              special;
    logic [EXP_W-1:0]  exp;
    logic [AW-1:0]     big_mant;
    logic [AW-1:0]     little_mant;
  } out_t;

  // Denormals share the exponent of the smallest normal.
  function automatic logic [EXP_W-1:0] eff_exp(input logic [EXP_W-1:0] e);
    return (e == '0) ? EXP_W'(1) : e;
  endfunction

  // Right shift that folds every discarded bit into bit 0 (sticky).
  function automatic logic [AW-1:0] shift_sticky(input logic [AW-1:0]    x,
                                                 input logic [EXP_W-1:0] d);
    logic [AW-1:0] lost_mask;
    logic [AW-1:0] r;
    lost_mask = '0;
    r         = '0;
    if (32'(d) >= 32'(AW)) begin
      r = {{(AW-1){1'b0}}, |x};
    end else begin
      lost_mask = ~({AW{1'b1}} << d);
      r         = x >> d;
      r[0]      = r[0] | (|(x & lost_mask));
    end
    return r;
  endfunction

  logic             vld_p1_q, vld_p1_d;
  s1_t              s1_q, s1_d;
  logic             out_valid_q, out_valid_d;
  out_t             out_q, out_d;

  logic             s1_load;
  logic             s2_load;
  logic [KW-1:0]    key_a;
  logic [KW-1:0]    key_b;
  logic             b_big;
  logic [EXP_W-1:0] big_raw_exp;
  logic [EXP_W-1:0] little_raw_exp;
  s1_t              s1_in;
  out_t             s2_res;

  // Handshake: a stage may load when it is empty or its successor is draining.
  always_comb begin
    s2_load = !out_valid_q || bus.out_ready;
    s1_load = !vld_p1_q || s2_load;
  end

  assign bus.in_ready = s1_load;

  // ---- stage 1: magnitude compare and swap ----
  always_comb begin
    key_a          = {bus.a_exp, bus.a_mant};
    key_b          = {bus.b_exp, bus.b_mant};
    b_big          = key_b > key_a;
    s1_in          = '0;
    big_raw_exp    = bus.a_exp;
    little_raw_exp = bus.b_exp;
    if (b_big) begin
      big_raw_exp       = bus.b_exp;
      little_raw_exp    = bus.a_exp;
      s1_in.big_sign    = bus.b_sign;
      s1_in.little_sign = bus.a_sign;
      s1_in.big_mant    = bus.b_mant;
      s1_in.little_mant = bus.a_mant;
    end else begin
      s1_in.big_sign    = bus.a_sign;
      s1_in.little_sign = bus.b_sign;
      s1_in.big_mant    = bus.a_mant;
      s1_in.little_mant = bus.b_mant;
    end
    s1_in.swap       = b_big;
    s1_in.special    = (&bus.a_exp) || (&bus.b_exp);
    s1_in.big_hid    = big_raw_exp != '0;
    s1_in.little_hid = little_raw_exp != '0;
    s1_in.big_exp    = eff_exp(big_raw_exp);
    s1_in.d          = eff_exp(big_raw_exp) - eff_exp(little_raw_exp);
  end

  // ---- stage 2: align little mantissa ----
  always_comb begin
    s2_res             = '0;
    s2_res.big_sign    = s1_q.big_sign;
    s2_res.little_sign = s1_q.little_sign;
    s2_res.swap        = s1_q.swap;
    s2_res.eff_sub     = s1_q.big_sign ^ s1_q.little_sign;
    s2_res.special     = s1_q.special;
    s2_res.exp         = s1_q.big_exp;
    s2_res.big_mant    = {s1_q.big_hid, s1_q.big_mant, 3'b000};
    s2_res.little_mant = shift_sticky({s1_q.little_hid, s1_q.little_mant, 3'b000}, s1_q.d);
  end

  always_comb begin
    vld_p1_d    = vld_p1_q;
    s1_d        = s1_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    if (s1_load) begin
      vld_p1_d = bus.in_valid;
      if (bus.in_valid) s1_d = s1_in;
    end
    if (s2_load) begin
      out_valid_d = vld_p1_q;
      if (vld_p1_q) out_d = s2_res;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1_q    <= 1'b0;
      s1_q        <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      vld_p1_q    <= vld_p1_d;
      s1_q        <= s1_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

  // ---- output registers ----
  assign bus.out_valid       = out_valid_q;
  assign bus.out_exp         = out_q.exp;
  assign bus.out_big_mant    = out_q.big_mant;
  assign bus.out_little_mant = out_q.little_mant;
  assign bus.out_big_sign    = out_q.big_sign;
  assign bus.out_little_sign = out_q.little_sign;
  assign bus.out_swap        = out_q.swap;
  assign bus.out_eff_sub     = out_q.eff_sub;
  assign bus.out_special     = out_q.special;

endmodule

// File: tb/tb_fp_align_pipe.sv
// Directed bench for fp_align_pipe: hand-computed alignment vectors, latency,
// throughput, backpressure stalls and asynchronous reset mid-stream.
module tb_fp_align_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  fp_align_if #(.EXP_W(8), .MANT_W(23)) bus ();

  fp_align_pipe #(.EXP_W(8), .MANT_W(23)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // flags = {big_sign, little_sign, swap, eff_sub, special}
  typedef struct {
    logic        asg; logic [7:0] aex; logic [22:0] amt;
    logic        bsg; logic [7:0] bex; logic [22:0] bmt;
    logic [7:0]  xe;  logic [26:0] xb;  logic [26:0] xl; logic [4:0] xf;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int i);
    bus.a_sign = vecs[i].asg; bus.a_exp = vecs[i].aex; bus.a_mant = vecs[i].amt;
    bus.b_sign = vecs[i].bsg; bus.b_exp = vecs[i].bex; bus.b_mant = vecs[i].bmt;
  endtask

  task automatic check_out(input int i, input string pfx);
    chk($sformatf("%s_v%0d_exp", pfx, i), bus.out_exp, vecs[i].xe);
    chk($sformatf("%s_v%0d_big", pfx, i), bus.out_big_mant, vecs[i].xb);
    chk($sformatf("%s_v%0d_little", pfx, i), bus.out_little_mant, vecs[i].xl);
    chk($sformatf("%s_v%0d_flags", pfx, i),
        {bus.out_big_sign, bus.out_little_sign, bus.out_swap, bus.out_eff_sub, bus.out_special},
        vecs[i].xf);
  endtask

  // One pair in an otherwise empty pipe; presented after edge E0, result after E0+2.
  task automatic single(input int i);
    @(posedge clk); #1;
    drive(i); bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk);
    chk($sformatf("lat_v%0d_in_ready", i), bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk($sformatf("lat_v%0d_early", i), bus.out_valid, 0);
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("lat_v%0d_valid", i), bus.out_valid, 1);
    check_out(i, "lat");
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("lat_v%0d_drained", i), bus.out_valid, 0);
  endtask

  // Streams vectors 0..n-1; bp selects out_ready pattern 1,0,0 repeating.
  task automatic run_stream(input int n, input bit bp, input string nm);
    int          sent = 0;
    int          got  = 0;
    int          cyc  = 0;
    int          cnt  = 0;
    bit          held = 0;
    bit          acc, drn;
    logic [63:0] h_a = '0;
    logic [63:0] h_b = '0;
    @(posedge clk); #1;
    while (got < n && cyc < 100) begin
      if (sent < n) begin drive(sent); bus.in_valid = 1'b1; end
      else bus.in_valid = 1'b0;
      bus.out_ready = bp ? (cyc % 3 == 0) : 1'b1;
      @(negedge clk);
      chk($sformatf("%s_c%0d_in_ready", nm, cyc), bus.in_ready, !(cnt == 2 && !bus.out_ready));
      if (held) begin
        chk($sformatf("%s_c%0d_hold_a", nm, cyc), {bus.out_exp, bus.out_big_mant}, h_a);
        chk($sformatf("%s_c%0d_hold_b", nm, cyc),
            {bus.out_valid, bus.out_little_mant, bus.out_big_sign, bus.out_little_sign,
             bus.out_swap, bus.out_eff_sub, bus.out_special}, h_b);
      end
      held = bus.out_valid && !bus.out_ready;
      if (held) begin
        h_a = {bus.out_exp, bus.out_big_mant};
        h_b = {bus.out_valid, bus.out_little_mant, bus.out_big_sign, bus.out_little_sign,
               bus.out_swap, bus.out_eff_sub, bus.out_special};
      end
      if (bus.out_valid && bus.out_ready && got < n) check_out(got, nm);
      acc = bus.in_valid && bus.in_ready;
      drn = bus.out_valid && bus.out_ready;
      @(posedge clk); #1;
      if (acc) sent++;
      if (drn) got++;
      cnt = cnt + int'(acc) - int'(drn);
      cyc++;
    end
    chk({nm, "_count"}, got, n);
    if (!bp) chk({nm, "_cycles"}, cyc, n + 2);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("%s_idle%0d", nm, k), bus.out_valid, 0);
    end
  endtask

  initial begin
    vecs[0] = '{1'b0, 8'd127, 23'h0,      1'b0, 8'd126, 23'h0,      8'd127, 27'h4000000, 27'h2000000, 5'b00000};
    vecs[1] = '{1'b0, 8'd126, 23'h0,      1'b1, 8'd127, 23'h0,      8'd127, 27'h4000000, 27'h2000000, 5'b10110};
    vecs[2] = '{1'b0, 8'd127, 23'h0,      1'b0, 8'd90,  23'h400001, 8'd127, 27'h4000000, 27'h0000001, 5'b00000};
    vecs[3] = '{1'b0, 8'd127, 23'h0,      1'b0, 8'd100, 23'h000003, 8'd127, 27'h4000000, 27'h0000001, 5'b00000};
    vecs[4] = '{1'b0, 8'd0,   23'h000001, 1'b0, 8'd1,   23'h0,      8'd1,   27'h4000000, 27'h0000008, 5'b00100};
    vecs[5] = '{1'b0, 8'd255, 23'h0,      1'b0, 8'd127, 23'h0,      8'd255, 27'h4000000, 27'h0000001, 5'b00001};
    vecs[6] = '{1'b0, 8'd127, 23'h000005, 1'b1, 8'd127, 23'h000005, 8'd127, 27'h4000028, 27'h4000028, 5'b01010};
    vecs[7] = '{1'b1, 8'd123, 23'h000001, 1'b0, 8'd127, 23'h0,      8'd127, 27'h4000000, 27'h0400001, 5'b01110};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drive(0);

    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_exp", bus.out_exp, 0);
    chk("rst_out_little", bus.out_little_mant, 0);
    #11 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_idle_valid", bus.out_valid, 0);

    for (int i = 0; i < 8; i++) single(i);

    run_stream(8, 1'b0, "full");
    run_stream(6, 1'b1, "bp");

    // Fill both stages with out_ready low, then reset between clock edges.
    @(posedge clk); #1;
    bus.out_ready = 1'b0; drive(0); bus.in_valid = 1'b1;
    @(posedge clk); #1;
    drive(1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("mid_full_valid", bus.out_valid, 1);
    chk("mid_full_in_ready", bus.in_ready, 0);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_big", bus.out_big_mant, 0);
    chk("mid_rst_exp", bus.out_exp, 0);
    #1 rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("post_rst_idle%0d", k), bus.out_valid, 0);
      chk($sformatf("post_rst_ready%0d", k), bus.in_ready, 1);
    end
    single(4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
